// File: rtl/ysyx_22040125_lsu.sv
// Load/store unit between execute and a 64-bit, dword-indexed data RAM.
// Aligned B/H/W/D loads with sign/zero extension. Sub-dword stores are done as
// read-modify-write. Misaligned requests are answered with an error and
// never touch the RAM.
module ysyx_22040125_lsu #(
    parameter int unsigned RAM_AW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [63:0]       req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [63:0]       resp_rdata,
    output logic              resp_err,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [63:0]       ram_wdata,
    output logic              ram_wen,
    input  logic [63:0]       ram_rdata
);

    localparam int unsigned DW      = 64;
    localparam int unsigned IDX_LSB = 3;
    localparam int unsigned IDX_MSB = RAM_AW + IDX_LSB - 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WAIT = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t            state;
    logic [RAM_AW-1:0] idx_q;
    logic [2:0]        off_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic              wen_q;
    logic [DW-1:0]     wdata_q;
    logic [DW-1:0]     wbuf_q;

    logic              misalign_c;
    logic [5:0]        shamt_c;
    logic [DW-1:0]     mask_c;
    logic [DW-1:0]     field_c;
    logic [DW-1:0]     load_c;
    logic [DW-1:0]     merge_c;

    // Address bits above the dword index do not select RAM words.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[DW-1:IDX_MSB+1];

    // Natural-alignment check on the incoming request.
    always_comb begin
        misalign_c = 1'b0;
        case (req_size)
            2'd0:    misalign_c = 1'b0;
            2'd1:    misalign_c = req_addr[0];
            2'd2:    misalign_c = |req_addr[1:0];
            default: misalign_c = |req_addr[2:0];
        endcase
    end

    // Field mask for the latched access size.
    always_comb begin
        mask_c = '1;
        case (size_q)
            2'd0:    mask_c = DW'(64'h0000_0000_0000_00FF);
            2'd1:    mask_c = DW'(64'h0000_0000_0000_FFFF);
            2'd2:    mask_c = DW'(64'h0000_0000_FFFF_FFFF);
            default: mask_c = '1;
        endcase
    end

    assign shamt_c = {off_q, 3'b000};
    assign field_c = ram_rdata >> shamt_c;

    // Extract and extend the loaded field.
    always_comb begin
        load_c = field_c;
        case (size_q)
            2'd0:    load_c = uns_q ? DW'(field_c[7:0])
                                    : {{56{field_c[7]}}, field_c[7:0]};
            2'd1:    load_c = uns_q ? DW'(field_c[15:0])
                                    : {{48{field_c[15]}}, field_c[15:0]};
            2'd2:    load_c = uns_q ? DW'(field_c[31:0])
                                    : {{32{field_c[31]}}, field_c[31:0]};
            default: load_c = field_c;
        endcase
    end

    // Merge store data into the dword read back from RAM.
    assign merge_c = (ram_rdata & ~(mask_c << shamt_c)) | ((wdata_q & mask_c) << shamt_c);

    // Transaction sequencer with latched request and registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx_q      <= '0;
            off_q      <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wbuf_q     <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        idx_q   <= req_addr[IDX_MSB:IDX_LSB];
                        off_q   <= req_addr[2:0];
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        wen_q   <= req_wen;
                        wdata_q <= req_wdata;
                        if (misalign_c) begin
                            resp_valid <= 1'b1;
                            resp_rdata <= '0;
                            resp_err   <= 1'b1;
                            state      <= RESP;
                        end else if (req_wen && (req_size == 2'd3)) begin
                            wbuf_q <= req_wdata;
                            state  <= WR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (wen_q) begin
                        wbuf_q <= merge_c;
                        state  <= WR;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_rdata <= load_c;
                        resp_err   <= 1'b0;
                        state      <= RESP;
                    end
                end
                WR: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state == IDLE);
    assign ram_addr  = idx_q;
    assign ram_wdata = wbuf_q;
    // Reset gates the write so an interrupted store leaves RAM untouched.
    assign ram_wen   = (state == WR) && !rst;

endmodule

// File: tb/tb_ysyx_22040125_lsu.sv
// Bench for ysyx_22040125_lsu: directed cases then random traffic, checked
// against a byte-addressed memory model.
module tb_ysyx_22040125_lsu;

    localparam int unsigned RAM_AW = 32;
    localparam int unsigned MBYTES = 2048;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [63:0]       req_addr;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [63:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [63:0]       resp_rdata;
    logic              resp_err;
    logic [RAM_AW-1:0] ram_addr;
    logic [63:0]       ram_wdata;
    logic              ram_wen;
    logic [63:0]       ram_rdata;
    logic              mem_clear;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    ysyx_22040125_lsu #(.RAM_AW(RAM_AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wen(ram_wen),
        .ram_rdata(ram_rdata)
    );

    // Data RAM: registered read, whole-dword write.
    logic [63:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= 64'd0;
            ram_rdata <= 64'd0;
        end else if (ram_wen) begin
            mem[ram_addr[7:0]] <= ram_wdata;
        end else begin
            ram_rdata <= mem[ram_addr[7:0]];
        end
    end

    // Reference memory, one entry per byte.
    logic [7:0] ref_mem [0:MBYTES-1];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_load(input logic [63:0] addr, input logic [1:0] size,
                                             input logic uns);
        int n    = 1 << size;
        int base = int'(addr[10:0]);
        logic [63:0] v = 64'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[base + i];
        if (!uns && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
        return v;
    endfunction

    // One complete transaction: issue, measure latency, check response, hold, handshake.
    task automatic txn(input logic wen, input logic [63:0] addr, input logic [1:0] size,
                       input logic uns, input logic [63:0] wd, input int hold,
                       input logic poke, input logic early, output logic [63:0] got);
        int          n    = 1 << size;
        int          base = int'(addr[10:0]);
        logic        mis;
        int          explat;
        logic [7:0]  exppat;
        logic [63:0] exprd;
        int          lat;
        logic [7:0]  pat;
        logic        done;
        mis    = (int'(addr[2:0]) % n) != 0;
        explat = mis ? 1 : (wen ? ((size == 2'd3) ? 2 : 4) : 3);
        exppat = (wen && !mis) ? ((size == 2'd3) ? 8'b0000_0001 : 8'b0000_0100) : 8'd0;
        exprd  = (mis || wen) ? 64'd0 : ref_load(addr, size, uns);
        if (wen && !mis) for (int i = 0; i < n; i++) ref_mem[base + i] = wd[8*i +: 8];

        @(negedge clk);
        check("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_wen = wen; req_addr = addr; req_size = size;
        req_unsigned = uns; req_wdata = wd; resp_ready = early;
        @(posedge clk);
        lat = 0; pat = 8'd0; done = 1'b0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat <= 8) pat[lat-1] = ram_wen;
            if (resp_valid) done = 1'b1;
            req_valid = 1'b0;
        end
        check("resp_seen", 64'(done), 64'd1);
        check("latency", 64'(lat), 64'(explat));
        check("wen_pattern", 64'(pat), 64'(exppat));
        check("resp_err", 64'(resp_err), 64'(mis));
        check("resp_rdata", resp_rdata, exprd);
        if (!mis) check("ram_addr", 64'(ram_addr), 64'(addr[RAM_AW+2:3]));
        got = resp_rdata;
        if (poke) begin
            req_valid = 1'b1; req_wen = 1'b1; req_addr = 64'd0; req_size = 2'd3;
            req_wdata = ~64'd0;
        end
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold_valid", 64'(resp_valid), 64'd1);
            check("hold_rdata", resp_rdata, got);
            check("hold_ready", 64'(req_ready), 64'd0);
            check("hold_no_wen", 64'(ram_wen), 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        check("post_valid", 64'(resp_valid), 64'd0);
        check("post_ready", 64'(req_ready), 64'd1);
        check("post_rdata", resp_rdata, got);
        check("post_err", 64'(resp_err), 64'(mis));
    endtask

    initial begin
        logic [63:0] got;
        logic [63:0] a;
        logic [1:0]  sz;
        logic        w;
        int          hold;
        logic        early;

        for (int i = 0; i < int'(MBYTES); i++) ref_mem[i] = 8'd0;
        rst = 1'b1; mem_clear = 1'b1;
        req_valid = 1'b0; req_wen = 1'b0; req_addr = 64'd0; req_size = 2'd0;
        req_unsigned = 1'b0; req_wdata = 64'd0; resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_rdata", resp_rdata, 64'd0);
        check("rst_resp_err", 64'(resp_err), 64'd0);
        check("rst_ram_wen", 64'(ram_wen), 64'd0);
        check("rst_ram_addr", 64'(ram_addr), 64'd0);
        check("rst_ram_wdata", ram_wdata, 64'd0);
        rst = 1'b0; mem_clear = 1'b0;

        // Dword store then dword load.
        txn(1'b1, 64'h40, 2'd3, 1'b0, 64'h1122334455667788, 0, 1'b0, 1'b0, got);
        txn(1'b0, 64'h40, 2'd3, 1'b0, 64'd0, 0, 1'b0, 1'b0, got);
        check("ld_40", got, 64'h1122334455667788);

        // Narrow loads and sign extension.
        txn(1'b0, 64'h47, 2'd0, 1'b0, 64'd0, 0, 1'b0, 1'b0, got);
        check("lb_47", got, 64'h0000000000000011);
        txn(1'b0, 64'h46, 2'd1, 1'b0, 64'd0, 0, 1'b0, 1'b0, got);
        check("lh_46", got, 64'h0000000000001122);
        txn(1'b1, 64'h44, 2'd2, 1'b0, 64'h80000000, 0, 1'b0, 1'b0, got);
        txn(1'b0, 64'h44, 2'd2, 1'b0, 64'd0, 0, 1'b0, 1'b0, got);
        check("lw_44", got, 64'hFFFFFFFF80000000);
        txn(1'b0, 64'h44, 2'd2, 1'b1, 64'd0, 0, 1'b0, 1'b0, got);
        check("lwu_44", got, 64'h0000000080000000);

        // Byte store read-modify-write.
        txn(1'b1, 64'h40, 2'd3, 1'b0, 64'h1122334455667788, 0, 1'b0, 1'b0, got);
        txn(1'b1, 64'h43, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFAB, 0, 1'b0, 1'b0, got);
        check("sb_mem", mem[8], 64'h11223344AB667788);

        // Misaligned accesses.
        txn(1'b0, 64'h42, 2'd2, 1'b0, 64'd0, 0, 1'b0, 1'b0, got);
        txn(1'b1, 64'h44, 2'd3, 1'b0, 64'hDEADBEEF, 0, 1'b0, 1'b0, got);
        check("sd_mis_mem", mem[8], 64'h11223344AB667788);

        // Back-pressured response with a request waiting.
        txn(1'b0, 64'h40, 2'd3, 1'b0, 64'd0, 5, 1'b1, 1'b0, got);
        check("mem0_untouched", mem[0], 64'd0);

        // Reset during the write phase of a byte store.
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 64'h43; req_size = 2'd0;
        req_wdata = 64'hCD;
        @(posedge clk);
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("wr_phase_wen", 64'(ram_wen), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rr_req_ready", 64'(req_ready), 64'd1);
        check("rr_resp_valid", 64'(resp_valid), 64'd0);
        check("rr_resp_rdata", resp_rdata, 64'd0);
        check("rr_resp_err", 64'(resp_err), 64'd0);
        check("rr_ram_wen", 64'(ram_wen), 64'd0);
        check("rr_ram_addr", 64'(ram_addr), 64'd0);
        check("rr_ram_wdata", ram_wdata, 64'd0);
        check("rr_mem", mem[8], 64'h11223344AB667788);
        rst = 1'b0;
        txn(1'b0, 64'h40, 2'd3, 1'b0, 64'd0, 0, 1'b0, 1'b0, got);
        check("rr_ld", got, 64'h11223344AB667788);

        // Random traffic; high address bits above the index must be ignored.
        for (int t = 0; t < 300; t++) begin
            w  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = {29'($urandom), 24'd0, 11'($urandom_range(0, int'(MBYTES) - 1))};
            if ($urandom_range(0, 1) == 1) a[2:0] = a[2:0] & ~3'((1 << sz) - 1);
            hold  = $urandom_range(0, 2);
            early = (hold == 0) && ($urandom_range(0, 3) == 0);
            txn(w, a, sz, 1'($urandom_range(0, 1)), {$urandom, $urandom}, hold,
                1'($urandom_range(0, 1)), early, got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/ysyx_22040125_lsu.md
# ysyx_22040125_lsu

Load/store unit that sits between the execute stage and the 64-bit data RAM. It drives the RAM's dword-indexed port, whose read data is registered with one-cycle latency and which writes only whole doublewords. It accepts byte-addressed B/H/W/D requests over a valid/ready handshake. It performs naturally-aligned loads with sign or zero extension, and performs sub-doubleword stores as read-modify-write. Misaligned accesses are flagged and never reach the RAM.

## Interface
- RAM_AW, 32, width of RAM dword index; index = req_addr[RAM_AW+2:3]; higher address bits ignored
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block accepts a request; equals (state==IDLE)
- req_wen  in  1  1=store, 0=load
- req_addr  in  64  byte address
- req_size  in  2  0=byte, 1=half, 2=word, 3=dword
- req_unsigned  in  1  loads: zero-extend when 1, sign-extend when 0; ignored for stores
- req_wdata  in  64  store data, right-aligned (low 8/16/32/64 bits used)
- resp_valid  out  1  response held until accepted
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  64  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned access; no RAM activity occurred
- ram_addr  out  RAM_AW  dword index to RAM
- ram_wdata  out  64  full dword to RAM
- ram_wen  out  1  RAM write enable
- ram_rdata  in  64  RAM registered read data, valid the cycle after the index is presented with ram_wen=0

## Operation
- States: IDLE, RD, WAIT, WR, RESP.
- IDLE: req_ready=1. On req_valid, latch addr, size, unsigned, wen and wdata, then:
  - misaligned (half: addr[0]≠0; word: addr[1:0]≠0; dword: addr[2:0]≠0) → RESP with err=1;
  - else dword store → WR with wbuf=wdata;
  - else → RD.
- RD: ram_addr=latched index, ram_wen=0 → WAIT.
- WAIT: ram_rdata valid; off=addr[2:0]*8.
  - Load: field=ram_rdata>>off, masked to size, extended per unsigned into resp_rdata → RESP.
  - Store: wbuf=(ram_rdata & ~(mask<<off)) | ((wdata & mask)<<off) → WR.
- WR: ram_addr=latched index, ram_wdata=wbuf, ram_wen=1 → RESP.
- RESP: resp_valid=1. On resp_ready → IDLE; resp_valid drops, resp_rdata/resp_err hold until the next response is loaded.
- ram_wen = (state==WR) && !rst. ram_addr and ram_wdata are driven from latched registers in all states (stable, 0 after reset).
- Mask: 0xFF, 0xFFFF, 0xFFFF_FFFF, all-ones for size 0–3.
- No request overlap: one outstanding transaction.

## Timing
- Acceptance edge E0 = edge with req_valid && req_ready.
- resp_valid first high in the cycle after:
  - misaligned: E0 (1 cycle);
  - dword store: E0+1 (2 cycles);
  - load: E0+2 (3 cycles);
  - sub-dword store: E0+3 (4 cycles).
- RAM write lands on the edge ending WR; a load issued in the next accepted request observes it.
- Back-to-back: new request accepted no earlier than the edge after the resp handshake; min 2 cycles per transaction.
- resp_ready held high before resp_valid is harmless; the handshake completes in the first RESP cycle.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, ram_wen=0, ram_addr=0, ram_wdata=0, latched regs=0.
- Reset in any state (including WR) → IDLE at that edge, no RAM write on that edge, pending response discarded.

## Test plan
- Dword store 0x1122334455667788 to addr 0x40, then dword load from 0x40 → ram_addr=8 both times, ram_wen=1 for exactly one cycle, load resp_rdata=0x1122334455667788, latencies 2 and 3 cycles.
- With dword 0x40 = 0x1122334455667788: lb addr 0x47 signed → 0x0000000000000011; lh 0x46 → 0x1122; lw 0x44 signed after a store of word 0x80000000 to 0x44 → 0xFFFFFFFF80000000; lwu → 0x0000000080000000.
- Byte store 0xAB to 0x43 on dword 0x1122334455667788 → RAM holds 0x11223344AB667788; the RD→WAIT→WR sequence is observed, 4-cycle latency.
- Misaligned lw 0x42 and sd 0x44 → resp_err=1, resp_rdata=0, ram_wen never asserted, 1-cycle latency.
- resp_ready held low 5 cycles → resp_valid and resp_rdata stable, req_ready=0 throughout; req_valid asserted meanwhile is not accepted.
- rst asserted during WR of a byte store → RAM dword unchanged, all outputs at reset values next cycle, req_ready=1.
